// File: rtl/approx_pkg.sv
// Shared constants and the combinational reference model for the
// lower-part-OR approximate adder.
package approx_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_BITS = 4;
    localparam int IDX_W           = $clog2(DEF_WIDTH);

    // Returns {carry_out, approx[DEF_WIDTH-1:0]} for k approximate LSBs.
    function automatic logic [DEF_WIDTH:0] loa_add(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b,
        input int                   k
    );
        logic [DEF_WIDTH-1:0] s;
        logic                 c;
        logic                 ai;
        logic                 bi;
        s = '0;
        c = 1'b0;
        if (k > 0) begin
            c = a[IDX_W'(k - 1)] & b[IDX_W'(k - 1)];
        end
        for (int i = 0; i < DEF_WIDTH; i++) begin
            ai = a[IDX_W'(i)];
            bi = b[IDX_W'(i)];
            if (i < k) begin
                s[IDX_W'(i)] = ai | bi;
            end else begin
                s[IDX_W'(i)] = ai ^ bi ^ c;
                c            = (ai & bi) | (c & (ai ^ bi));
            end
        end
        return {c, s};
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used for the exact upper ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/approx_adder.sv
// Registered lower-part-OR approximate adder with a parallel exact sum,
// one operand pair in and one result pair out every clock.
module approx_adder
    import approx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH:0]   sumc,
    input  logic             rst_n
);

    localparam int K = APPROX_BITS;

    logic [WIDTH-1:0] approx;
    logic [WIDTH:K]   carry;    // carry[K] is the carry into the upper part
    logic [WIDTH-1:0] exact;

    assign exact = a + b;

    genvar i;
    generate
        for (i = 0; i < K; i++) begin : g_lower
            assign approx[i] = a[i] | b[i];
        end

        if (K == 0) begin : g_cin_none
            assign carry[K] = 1'b0;
        end else begin : g_cin_msb
            // The top approximate bit pair generates the only carry into
            // the exact part; lower carries are deliberately dropped.
            assign carry[K] = a[K-1] & b[K-1];
        end

        for (i = K; i < WIDTH; i++) begin : g_upper
            full_adder u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (carry[i]),
                .s  (approx[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            sumc <= '0;
        end else begin
            sum  <= exact;
            sumc <= {carry[WIDTH], approx};
        end
    end

endmodule

// File: tb/tb_approx_adder.sv
// Directed and streaming checks for approx_adder (k=4) plus an exact
// instance (k=0), compared against hand values and loa_add.
module tb_approx_adder;
    import approx_pkg::*;

    localparam int STREAM_LEN = 4096;
    localparam int RST_AT     = 2000;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic [8:0] sumc;
    logic [7:0] sum0;
    logic [8:0] sumc0;

    int errors = 0;
    int checks = 0;

    approx_adder #(.WIDTH(8), .APPROX_BITS(4)) dut (
        .a     (a),
        .b     (b),
        .clk   (clk),
        .sum   (sum),
        .sumc  (sumc),
        .rst_n (rst_n)
    );

    approx_adder #(.WIDTH(8), .APPROX_BITS(0)) dut_exact (
        .a     (a),
        .b     (b),
        .clk   (clk),
        .sum   (sum0),
        .sumc  (sumc0),
        .rst_n (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL timeout: simulation did not finish, got no summary, required completion");
        $fatal(1, "timeout");
    end

    // Drive on the falling edge, let one rising edge capture, sample on the next falling edge.
    task automatic apply(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        a = va;
        b = vb;
        @(negedge clk);
    endtask

    task automatic expect_pair(input string name, input logic [7:0] es, input logic [8:0] ec);
        checks++;
        if (sum !== es) begin
            errors++;
            $display("FAIL %s sum: got %h, required %h", name, sum, es);
        end
        checks++;
        if (sumc !== ec) begin
            errors++;
            $display("FAIL %s sumc: got %h, required %h", name, sumc, ec);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expect_pair("reset_async", 8'h00, 9'h000);
        checks++;
        if (sumc0 !== 9'h000 || sum0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_async_exact: got %h/%h, required 000/00", sumc0, sum0);
        end
        @(posedge clk);
        #1;
        expect_pair("reset_held", 8'h00, 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_carry_chain();
        apply(8'hFF, 8'hFF);
        expect_pair("carry_chain", 8'hFE, 9'h1FF);
        checks++;
        if (sumc0 !== 9'h1FE) begin
            errors++;
            $display("FAIL carry_chain_exact: got %h, required 1fe", sumc0);
        end
    endtask

    task automatic test_lower_error();
        apply(8'h0F, 8'h01);
        expect_pair("lower_error", 8'h10, 9'h00F);
        apply(8'h05, 8'h0A);
        expect_pair("lower_or_disjoint", 8'h0F, 9'h00F);
    endtask

    task automatic test_boundary();
        apply(8'h88, 8'h08);
        expect_pair("boundary_carry", 8'h90, 9'h098);
        apply(8'h80, 8'h80);
        expect_pair("upper_overflow", 8'h00, 9'h100);
    endtask

    task automatic test_exact_equiv();
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] ref9;
        apply(8'h30, 8'h50);
        expect_pair("exact_equiv", 8'h80, 9'h080);
        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply(ra, rb);
            ref9 = {1'b0, ra} + {1'b0, rb};
            checks++;
            if (sumc0 !== ref9) begin
                errors++;
                $display("FAIL k0_sumc a=%h b=%h: got %h, required %h", ra, rb, sumc0, ref9);
            end
            checks++;
            if (sum0 !== sumc0[7:0]) begin
                errors++;
                $display("FAIL k0_sum a=%h b=%h: got %h, required %h", ra, rb, sum0, sumc0[7:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_sum;
        logic [8:0] exp_sumc;
        logic [8:0] tmp9;
        logic       prev_valid;
        prev_valid = 1'b0;
        exp_sum    = '0;
        exp_sumc   = '0;
        for (int n = 0; n < STREAM_LEN; n++) begin
            @(negedge clk);
            if (prev_valid) begin
                checks++;
                if (sum !== exp_sum) begin
                    errors++;
                    $display("FAIL stream_sum cycle %0d: got %h, required %h", n, sum, exp_sum);
                end
                checks++;
                if (sumc !== exp_sumc) begin
                    errors++;
                    $display("FAIL stream_sumc cycle %0d: got %h, required %h", n, sumc, exp_sumc);
                end
            end
            if (n == RST_AT) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                expect_pair("stream_reset_drop", 8'h00, 9'h000);
                @(posedge clk);
                #1;
                expect_pair("stream_reset_hold", 8'h00, 9'h000);
                @(negedge clk);
                rst_n = 1'b1;
            end
            a          = 8'($urandom);
            b          = 8'($urandom);
            tmp9       = {1'b0, a} + {1'b0, b};
            exp_sum    = tmp9[7:0];
            exp_sumc   = loa_add(a, b, 4);
            prev_valid = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        a     = '0;
        b     = '0;
        test_reset();
        test_carry_chain();
        test_lower_error();
        test_boundary();
        test_exact_equiv();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
